// File: rtl/bit8serialsubtractor.sv
// Bit-serial subtractor: {Bout, D} = A - B - Bin, one bit per clock, LSB first.
// Define BIT8SUB_SAT_EN to clamp D to zero whenever the result underflows.
module bit8serialsubtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             bit_a;
    logic             bit_b;
    logic             diff;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        bit_a     = op_a_q[0];
        bit_b     = op_b_q[0];
        diff      = bit_a ^ bit_b ^ br_q;
        br_next   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        res_shift = {diff, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                // DONE accepts Start directly so operations can run back to back.
                if (Start) begin
                    state_d = StRun;
                    op_a_d  = A;
                    op_b_d  = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                br_d   = br_next;
                res_d  = res_shift;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    bout_d  = br_next;
`ifdef BIT8SUB_SAT_EN
                    d_d     = br_next ? '0 : res_shift;
`else
                    d_d     = res_shift;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        Busy = (state_q == StRun);
        Done = (state_q == StDone);
        D    = d_q;
        Bout = bout_q;
    end

endmodule

// File: tb/tb_bit8serialsubtractor.sv
// Randomised self-checking bench for bit8serialsubtractor against an arithmetic model.
// Honours BIT8SUB_SAT_EN the same way as the design.
module tb_bit8serialsubtractor;

    localparam int unsigned W = 8;

    logic         Clk   = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         Bin   = 1'b0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] D;
    logic         Bout;

    int n_vec = 0;
    int n_err = 0;

    bit8serialsubtractor #(.WIDTH(W)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .Start(Start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .Busy (Busy),
        .Done (Done),
        .D    (D),
        .Bout (Bout)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
`ifdef BIT8SUB_SAT_EN
        if (r[W]) r[W-1:0] = '0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted Start at edge k completes on edge k+W.
    int         edge_n     = 0;
    int         start_edge = -1;
    logic [W:0] pend       = '0;
    logic       m_busy     = 1'b0;
    logic       m_done     = 1'b0;
    logic [W-1:0] m_d      = '0;
    logic       m_bout     = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            edge_n     = 0;
            start_edge = -1;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_d        = '0;
            m_bout     = 1'b0;
        end else begin
            edge_n++;
            m_done = 1'b0;
            if (start_edge >= 0 && edge_n == start_edge + W) begin
                {m_bout, m_d} = pend;
                m_done        = 1'b1;
            end
            if (Start && (start_edge < 0 || edge_n > start_edge + W)) begin
                start_edge = edge_n;
                pend       = golden(A, B, Bin);
            end
            m_busy = (start_edge >= 0) && (edge_n < start_edge + W);
        end
    end

    always @(negedge Clk) begin
        check("cycle {busy,done,bout,d}", {21'd0, Busy, Done, Bout, D},
              {21'd0, m_busy, m_done, m_bout, m_d});
    end

    // Runs one operation; optionally re-pulses Start with other operands mid-run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int restart_at);
        logic [W:0] exp;
        int lat;
        int busy_cnt;
        exp = golden(a, b, bin);
        @(posedge Clk); #1;
        A = a; B = b; Bin = bin; Start = 1'b1;
        @(posedge Clk); #1;
        Start    = 1'b0;
        lat      = 0;
        busy_cnt = Busy ? 1 : 0;
        while (!Done && lat < 3 * W) begin
            @(posedge Clk); #1;
            lat++;
            if (lat == restart_at) begin
                Start = 1'b1; A = 8'h01; B = 8'h00;
            end else if (lat == restart_at + 1) begin
                Start = 1'b0;
            end
            if (Busy) busy_cnt++;
        end
        check("latency", lat, W);
        check("busy_cycles", busy_cnt, W);
        check("result_d", D, exp[W-1:0]);
        check("result_bout", Bout, exp[W]);
    endtask

    initial begin
        logic [W:0] e2;
        #1;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_d", D, 0);
        check("reset_bout", Bout, 0);
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;

        // Pin the model with hand-computed values.
        check("model_basic", golden(8'h5A, 8'h21, 1'b0), 9'h039);
`ifdef BIT8SUB_SAT_EN
        check("model_underflow", golden(8'h00, 8'h01, 1'b0), 9'h100);
        check("model_borrow_in", golden(8'hFF, 8'hFF, 1'b1), 9'h100);
`else
        check("model_underflow", golden(8'h00, 8'h01, 1'b0), 9'h1FF);
        check("model_borrow_in", golden(8'hFF, 8'hFF, 1'b1), 9'h1FF);
`endif

        run_op(8'h5A, 8'h21, 1'b0, -1);
        run_op(8'h00, 8'h01, 1'b0, -1);
        run_op(8'hFF, 8'hFF, 1'b1, -1);
        run_op(8'h5A, 8'h21, 1'b0, 3);

        // Start held through DONE: second operation starts with no idle cycle.
        @(posedge Clk); #1;
        A = 8'h5A; B = 8'h21; Bin = 1'b0; Start = 1'b1;
        @(posedge Clk); #1;
        A = 8'h10; B = 8'h20; Bin = 1'b1;
        repeat (W) @(posedge Clk);
        #1;
        check("b2b_first_done", Done, 1);
        check("b2b_first_d", D, 8'h39);
        @(posedge Clk); #1;
        Start = 1'b0;
        check("b2b_no_idle_busy", Busy, 1);
        check("b2b_no_idle_done", Done, 0);
        repeat (W) @(posedge Clk);
        #1;
        e2 = golden(8'h10, 8'h20, 1'b1);
        check("b2b_second_done", Done, 1);
        check("b2b_second_d", D, e2[W-1:0]);
        check("b2b_second_bout", Bout, e2[W]);

        // Asynchronous reset on cycle 4 of RUN after a result with Bout = 1.
        run_op(8'h00, 8'h01, 1'b0, -1);
        @(posedge Clk); #1;
        A = 8'hC3; B = 8'h12; Bin = 1'b0; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_d", D, 0);
        check("abort_bout", Bout, 0);
        repeat (W + 2) @(posedge Clk);
        #1;
        check("abort_no_done", Done, 0);
        Rst_n = 1'b1;
        run_op(8'hC3, 8'h12, 1'b0, -1);

        for (int i = 0; i < 1500; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), -1);
        end

        @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
